// File: rtl/tqvp_bus_pkg.sv
// tqvp_bus_pkg: shared size/strobe encodings, initiator FSM states and the size-mask helper
package tqvp_bus_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  function automatic logic [31:0] size_mask(input logic [1:0] sz, input logic [31:0] d);
    return sz == SZ_BYTE ? {24'd0, d[7:0]} :
           sz == SZ_HALF ? {16'd0, d[15:0]} :
           sz == SZ_WORD ? d : 32'd0;
  endfunction
endpackage

// File: rtl/tqvp_bus_initiator.sv
// tqvp_bus_initiator: valid/ready host for the tqvp peripheral register bus with per-access timeout
module tqvp_bus_initiator
  import tqvp_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t      state, state_nxt;
  logic [7:0]  timer, timer_nxt;
  logic        wr, wr_nxt;
  logic [1:0]  sz, sz_nxt, write_n_nxt, read_n_nxt;
  logic [5:0]  addr_nxt;
  logic [31:0] wdata_nxt, rdata_nxt;
  logic        valid_nxt, err_nxt;
  assign req_ready = state == IDLE;
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    wr_nxt      = wr;
    sz_nxt      = sz;
    addr_nxt    = bus_address;
    wdata_nxt   = bus_wdata;
    write_n_nxt = SZ_NONE;
    read_n_nxt  = SZ_NONE;
    valid_nxt   = rsp_valid;
    err_nxt     = rsp_err;
    rdata_nxt   = rsp_rdata;
    case (state)
      IDLE: if (req_valid) begin
        wr_nxt = req_write;
        sz_nxt = req_size;
        timer_nxt = 8'd0;
        if (req_size == SZ_NONE) begin
          state_nxt = RESP;
          valid_nxt = 1'b1;
          err_nxt   = 1'b1;
          rdata_nxt = 32'd0;
        end else begin
          state_nxt   = ACCESS;
          addr_nxt    = req_addr;
          wdata_nxt   = size_mask(req_size, req_wdata);
          write_n_nxt = req_write ? req_size : SZ_NONE;
          read_n_nxt  = req_write ? SZ_NONE : req_size;
        end
      end
      ACCESS: if (bus_ready || timer + 8'd1 == TO) begin
        // a late data_ready still beats the timeout in the same cycle
        state_nxt = RESP;
        valid_nxt = 1'b1;
        err_nxt   = !bus_ready;
        rdata_nxt = bus_ready && !wr ? size_mask(sz, bus_rdata) : 32'd0;
      end else begin
        timer_nxt   = timer + 8'd1;
        write_n_nxt = bus_write_n;
        read_n_nxt  = bus_read_n;
      end
      RESP: if (rsp_ready) begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= 8'd0;
      wr          <= 1'b0;
      sz          <= SZ_NONE;
      bus_address <= 6'd0;
      bus_wdata   <= 32'd0;
      bus_write_n <= SZ_NONE;
      bus_read_n  <= SZ_NONE;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'd0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      wr          <= wr_nxt;
      sz          <= sz_nxt;
      bus_address <= addr_nxt;
      bus_wdata   <= wdata_nxt;
      bus_write_n <= write_n_nxt;
      bus_read_n  <= read_n_nxt;
      rsp_valid   <= valid_nxt;
      rsp_err     <= err_nxt;
      rsp_rdata   <= rdata_nxt;
    end
  end
endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// tb_tqvp_bus_initiator: directed checks of handshake timing, masking, timeout, backpressure and reset
module tb_tqvp_bus_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0, bus_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [5:0]  req_addr = 6'd0;
  logic [31:0] req_wdata = 32'd0, bus_rdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, bus_wdata;
  logic [5:0]  bus_address;
  logic [1:0]  bus_write_n, bus_read_n;
  int          checks = 0, failures = 0;
  int          n_strobe, lat;
  logic [1:0]  w_seen, r_seen;
  logic [31:0] wd_seen;
  logic [5:0]  a_seen;

  tqvp_bus_initiator #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_write_n(bus_write_n),
    .bus_read_n(bus_read_n), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // starts at a negedge; peripheral raises bus_ready in strobe cycle k (0 = never)
  task automatic xfer(input logic w, input logic [1:0] sz, input logic [5:0] a,
                      input logic [31:0] wd, input int k, input logic [31:0] prd);
    n_strobe = 0; lat = 0; w_seen = 2'b11; r_seen = 2'b11; wd_seen = 32'd0; a_seen = 6'd0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    bus_rdata = prd; bus_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) lat = i;
      else if (bus_write_n != 2'b11 || bus_read_n != 2'b11) begin
        n_strobe++;
        w_seen = bus_write_n; r_seen = bus_read_n; wd_seen = bus_wdata; a_seen = bus_address;
        bus_ready = (n_strobe == k);
      end else bus_ready = 1'b0;
    end
    bus_ready = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("consume_valid", 32'(rsp_valid), 32'd0);
    chk("consume_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_write_n", 32'(bus_write_n), 32'd3);
    chk("rst_read_n", 32'(bus_read_n), 32'd3);
    chk("rst_address", 32'(bus_address), 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    xfer(1'b1, 2'b10, 6'h00, 32'hA0000003, 1, 32'h0);
    chk("ww_strobes", n_strobe, 1);
    chk("ww_write_n", 32'(w_seen), 32'd2);
    chk("ww_read_n", 32'(r_seen), 32'd3);
    chk("ww_wdata", wd_seen, 32'hA0000003);
    chk("ww_latency", lat, 2);
    chk("ww_err", 32'(rsp_err), 32'd0);
    chk("ww_rdata", rsp_rdata, 32'd0);
    chk("ww_req_ready", 32'(req_ready), 32'd0);
    consume();

    xfer(1'b0, 2'b00, 6'h18, 32'h0, 1, 32'hDEADBE5A);
    chk("br_read_n", 32'(r_seen), 32'd0);
    chk("br_write_n", 32'(w_seen), 32'd3);
    chk("br_address", 32'(a_seen), 32'h18);
    chk("br_rdata", rsp_rdata, 32'h0000005A);
    chk("br_err", 32'(rsp_err), 32'd0);
    consume();

    xfer(1'b0, 2'b01, 6'h04, 32'h0, 3, 32'h12345678);
    chk("hr_strobes", n_strobe, 3);
    chk("hr_read_n", 32'(r_seen), 32'd1);
    chk("hr_latency", lat, 4);
    chk("hr_rdata", rsp_rdata, 32'h00005678);
    consume();

    xfer(1'b1, 2'b00, 6'h02, 32'hFFFFFFA5, 2, 32'h0);
    chk("bw_wdata", wd_seen, 32'h000000A5);
    chk("bw_write_n", 32'(w_seen), 32'd0);
    chk("bw_strobes", n_strobe, 2);
    consume();

    xfer(1'b0, 2'b10, 6'h10, 32'h0, 0, 32'hCAFEF00D);
    chk("to_strobes", n_strobe, 4);
    chk("to_latency", lat, 5);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    consume();
    xfer(1'b0, 2'b10, 6'h10, 32'h0, 4, 32'hCAFEF00D);
    chk("after_to_strobes", n_strobe, 4);
    chk("after_to_err", 32'(rsp_err), 32'd0);
    chk("after_to_rdata", rsp_rdata, 32'hCAFEF00D);
    consume();

    xfer(1'b1, 2'b11, 6'h3F, 32'h12345678, 1, 32'h0);
    chk("ill_strobes", n_strobe, 0);
    chk("ill_latency", lat, 1);
    chk("ill_err", 32'(rsp_err), 32'd1);
    chk("ill_rdata", rsp_rdata, 32'd0);
    consume();

    xfer(1'b0, 2'b10, 6'h08, 32'h0, 1, 32'h11223344);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h11223344);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    consume();

    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 6'h2A; bus_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_read_n", 32'(bus_read_n), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_read_n", 32'(bus_read_n), 32'd3);
    chk("arst_write_n", 32'(bus_write_n), 32'd3);
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_address", 32'(bus_address), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_valid_after", 32'(rsp_valid), 32'd0);
    xfer(1'b0, 2'b01, 6'h06, 32'h0, 1, 32'hBEEF7777);
    chk("post_rst_rdata", rsp_rdata, 32'h00007777);
    chk("post_rst_latency", lat, 2);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
